// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_pkg
// Description : Shared types, funct3 codes, splice controls and small decode
//               helpers for the memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // funct3 access codes (D/W/H are shared by loads and stores)
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_B  = 3'b000;  // SB
  localparam logic [2:0] F3_BU = 3'b100;  // LBU

  // Load splice controls
  typedef enum logic [1:0] {
    SPL_LD  = 2'd0,
    SPL_LW  = 2'd1,
    SPL_LH  = 2'd2,
    SPL_LBU = 2'd3
  } spl_e;

  // Legal funct3 set differs between loads and stores
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return (f3 == F3_D) || (f3 == F3_W) || (f3 == F3_H) || (f3 == F3_B);
    else       return (f3 == F3_D) || (f3 == F3_W) || (f3 == F3_H) || (f3 == F3_BU);
  endfunction

  // Byte-lane mask for an access size; f3[1:0] encodes log2(size) for all legal codes
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b11:   return 8'hFF;
      2'b10:   return 8'h0F;
      2'b01:   return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  // Address not a multiple of the access size; bytes never misalign
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] lo);
    case (sz)
      2'b11:   return lo != 3'b000;
      2'b10:   return lo[1:0] != 2'b00;
      2'b01:   return lo[0];
      default: return 1'b0;
    endcase
  endfunction

  // Map a load funct3 onto its splice control
  function automatic spl_e spl_of(input logic [2:0] f3);
    case (f3)
      F3_D:    return SPL_LD;
      F3_W:    return SPL_LW;
      F3_H:    return SPL_LH;
      default: return SPL_LBU;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Pipeline request/response and memory-side bus bundle for the
//               memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
  // Pipeline request side
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  // Memory side
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  // Response / status
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        stall;

  // Controller view
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
           rsp_valid, rsp_data, rsp_err, stall
  );

  // Pipeline + memory environment view
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
           rsp_valid, rsp_data, rsp_err, stall
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl_load_splicer.sv
`default_nettype none
// ============================================================================
// Module      : load_splicer
// Description : Trims a right-aligned load doubleword to the access size,
//               sign-extending LW/LH and zero-extending LBU.
// Revision    : 1.0 - initial release
// ============================================================================
module load_splicer
  import mem_access_ctrl_pkg::*;
(
  input  logic [63:0] data_i,
  input  spl_e        ctrl_i,
  output logic [63:0] data_o
);

  // Size/extension select
  always_comb begin
    data_o = data_i;
    case (ctrl_i)
      SPL_LD:  data_o = data_i;
      SPL_LW:  data_o = {{32{data_i[31]}}, data_i[31:0]};
      SPL_LH:  data_o = {{48{data_i[15]}}, data_i[15:0]};
      SPL_LBU: data_o = {56'd0, data_i[7:0]};
      default: data_o = data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Single-outstanding load/store controller between a pipeline
//               and a doubleword memory: lane steering, alignment/funct3
//               checking, ack timeout and load result splicing.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           reset,
  mem_access_ctrl_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [2:0]        addr_lo_q;
  logic              acked_q;     // ack already seen in the ACCESS cycle
  logic [63:0]       rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              req_ready_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [63:0]       mem_addr_q;
  logic [63:0]       mem_wdata_q;
  logic [7:0]        mem_wstrb_q;
  logic              rsp_valid_q;
  logic [63:0]       rsp_data_q;
  logic              rsp_err_q;
  logic              stall_q;

  logic              w_bad_req;
  logic [63:0]       w_rdata_src;
  logic [63:0]       w_rdata_shift;
  logic [63:0]       w_spliced;
  spl_e              w_spl;

  assign w_bad_req = !f3_legal(bus.req_write, bus.req_funct3) ||
                     misaligned(bus.req_funct3[1:0], bus.req_addr[2:0]);

  // An ack in WAIT is spliced straight from the bus; an early one from the capture
  assign w_rdata_src   = acked_q ? rdata_q : bus.mem_rdata;
  assign w_rdata_shift = w_rdata_src >> {addr_lo_q, 3'b000};
  assign w_spl         = spl_of(f3_q);

  load_splicer u_splicer (
    .data_i (w_rdata_shift),
    .ctrl_i (w_spl),
    .data_o (w_spliced)
  );

  // Controller FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      f3_q        <= 3'b000;
      addr_lo_q   <= 3'b000;
      acked_q     <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            write_q     <= bus.req_write;
            f3_q        <= bus.req_funct3;
            addr_lo_q   <= bus.req_addr[2:0];
            mem_addr_q  <= {bus.req_addr[63:3], 3'b000};
            mem_wdata_q <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
            mem_wstrb_q <= size_mask(bus.req_funct3[1:0]) << bus.req_addr[2:0];
            req_ready_q <= 1'b0;
            stall_q     <= 1'b1;
            if (w_bad_req) begin
              // Rejected without touching memory
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state_q  <= ST_ACCESS;
              mem_en_q <= 1'b1;
              mem_we_q <= bus.req_write;
            end
          end
        end
        ST_ACCESS: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
          if (bus.mem_ack) begin
            acked_q <= 1'b1;
            rdata_q <= bus.mem_rdata;
          end
        end
        ST_WAIT: begin
          if (acked_q || bus.mem_ack) begin
            if (!acked_q) rdata_q <= bus.mem_rdata;
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= write_q ? 64'd0 : w_spliced;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          stall_q     <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
          acked_q     <= 1'b0;
          cnt_q       <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.stall     = stall_q;

endmodule
`default_nettype wire
